// File: rtl/alb_mss_sram_pkg.sv
// Shared types, limits and the byte-lane merge used by the two-port SRAM model.
// The merge is written at a fixed maximum width; callers resize to their own word.
package alb_mss_sram_pkg;

    typedef enum logic {
        RBW = 1'b0,
        WT  = 1'b1
    } rw_mode_e;

    localparam int MAX_RD_LAT = 4;
    localparam int MAX_DATA_W = 1024;

    typedef logic [MAX_DATA_W-1:0] word_max_t;
    typedef logic [MAX_DATA_W-1:0] lane_max_t;

    // Bit b belongs to lane b/byte_w; enabled lanes take the new data.
    function automatic word_max_t lane_merge(input word_max_t old_word,
                                             input word_max_t new_word,
                                             input lane_max_t bie,
                                             input int        byte_w);
        word_max_t merged;
        for (int b = 0; b < MAX_DATA_W; b++) begin
            merged[b] = bie[b / byte_w] ? new_word[b] : old_word[b];
        end
        return merged;
    endfunction

endpackage

// File: rtl/alb_mss_fpga_sram_2p_mem_if.sv
// Bus bundle for the two-port SRAM: rw0 read/write port and r1 read-only port.
// master drives requests and consumes read data; slave is the memory side.
interface alb_mss_fpga_sram_2p_mem_if #(
    parameter int DATA_W = 128,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 28
);
    localparam int NB = DATA_W / BYTE_W;

    logic [ADDR_W-1:0] rw0addr;
    logic [DATA_W-1:0] rw0di;
    logic              rw0we;
    logic [NB-1:0]     rw0bie;
    logic              rw0re;
    logic [DATA_W-1:0] rw0do;
    logic              rw0dv;

    logic [ADDR_W-1:0] r1addr;
    logic              r1re;
    logic [DATA_W-1:0] r1do;
    logic              r1dv;

    modport master (
        output rw0addr, rw0di, rw0we, rw0bie, rw0re, r1addr, r1re,
        input  rw0do, rw0dv, r1do, r1dv
    );

    modport slave (
        input  rw0addr, rw0di, rw0we, rw0bie, rw0re, r1addr, r1re,
        output rw0do, rw0dv, r1do, r1dv
    );

endinterface

// File: rtl/alb_mss_sram_rd_pipe.sv
// Read-data pipeline: RD_LAT stages of valid/data with synchronous flush.
// Data stages load only on a valid beat, so the output holds its last value when idle.
module alb_mss_sram_rd_pipe #(
    parameter int DATA_W = 128,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    logic [RD_LAT-1:0] stage_vld;
    logic [DATA_W-1:0] stage_data [RD_LAT];

    assign stage_vld[0]  = in_valid;
    assign stage_data[0] = in_data;

    for (genvar g = 1; g < RD_LAT; g++) begin : g_link
        assign stage_vld[g]  = vld_q[g-1];
        assign stage_data[g] = data_q[g-1];
    end

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // pre-edge value, which is what makes this a shift register and not a wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q <= stage_vld;
            for (int i = 0; i < RD_LAT; i++) begin
                if (stage_vld[i]) begin
                    data_q[i] <= stage_data[i];
                end
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/alb_mss_fpga_sram_2p_mem.sv
// Two-port synchronous SRAM model: rw0 byte-masked read/write, r1 read-only,
// configurable read latency and read/write collision behaviour.
module alb_mss_fpga_sram_2p_mem
    import alb_mss_sram_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int BYTE_W  = 8,
    parameter int ADDR_W  = 28,
    parameter int RD_LAT  = 1,
    parameter int RW_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    alb_mss_fpga_sram_2p_mem_if.slave     bus
);

    localparam int       DEPTH = 1 << ADDR_W;
    localparam rw_mode_e MODE  = (RW_MODE == 1) ? WT : RBW;

    if (BYTE_W < 1 || (DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
        $error("alb_mss_fpga_sram_2p_mem: DATA_W (%0d) must be a multiple of BYTE_W (%0d)",
               DATA_W, BYTE_W);
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
        $error("alb_mss_fpga_sram_2p_mem: RD_LAT (%0d) must be in 1..%0d", RD_LAT, MAX_RD_LAT);
    end
    if (DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("alb_mss_fpga_sram_2p_mem: DATA_W (%0d) exceeds %0d", DATA_W, MAX_DATA_W);
    end
    if (RW_MODE != 0 && RW_MODE != 1) begin : g_bad_mode
        $error("alb_mss_fpga_sram_2p_mem: RW_MODE (%0d) must be 0 or 1", RW_MODE);
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              rw0_rd;
    logic              r1_rd;
    logic              r1_hit;
    logic [DATA_W-1:0] rw0_old;
    logic [DATA_W-1:0] r1_old;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rw0_rd_word;
    logic [DATA_W-1:0] r1_rd_word;

    assign wr_en  = !rst && bus.rw0we && (|bus.rw0bie);
    assign rw0_rd = !rst && bus.rw0re;
    assign r1_rd  = !rst && bus.r1re;
    assign r1_hit = wr_en && (bus.r1addr == bus.rw0addr);

    // The merged word feeds both the array write and the write-through bypass,
    // so a colliding reader sees exactly what lands in the array.
    // NOTE: every always_comb output is assigned on every path; a missed branch
    // here would infer a latch instead of a mux.
    always_comb begin
        rw0_old     = mem[bus.rw0addr];
        r1_old      = mem[bus.r1addr];
        wr_word     = DATA_W'(lane_merge(word_max_t'(rw0_old),
                                         word_max_t'(bus.rw0di),
                                         lane_max_t'(bus.rw0bie),
                                         BYTE_W));
        rw0_rd_word = rw0_old;
        r1_rd_word  = r1_old;
        if (MODE == WT) begin
            if (wr_en) begin
                rw0_rd_word = wr_word;
            end
            if (r1_hit) begin
                r1_rd_word = wr_word;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would need one write per word
    // and would stop the tools mapping it onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[bus.rw0addr] <= wr_word;
        end
    end

    alb_mss_sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rw0_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rw0_rd),
        .in_data   (rw0_rd_word),
        .out_valid (bus.rw0dv),
        .out_data  (bus.rw0do)
    );

    alb_mss_sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_r1_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r1_rd),
        .in_data   (r1_rd_word),
        .out_valid (bus.r1dv),
        .out_data  (bus.r1do)
    );

endmodule

// File: tb/tb_alb_mss_fpga_sram_2p_mem.sv
// Bench for the two-port SRAM: six instances (both collision modes, latencies 1..4)
// share one stimulus stream and are compared against a history-based reference model.
module tb_alb_mss_fpga_sram_2p_mem;

    localparam int DW   = 64;
    localparam int BW   = 8;
    localparam int AW   = 4;
    localparam int NB   = DW / BW;
    localparam int NI   = 6;
    localparam int MAXE = 16384;

    // Instance k: mode = MODE_BITS[k] (1 = write-through), latency = LAT_BITS[3k +: 3].
    localparam logic [NI-1:0]   MODE_BITS = 6'b011010;
    localparam logic [3*NI-1:0] LAT_BITS  = {3'd2, 3'd3, 3'd4, 3'd4, 3'd1, 3'd1};

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rw0addr;
    logic [DW-1:0] rw0di;
    logic          rw0we;
    logic [NB-1:0] rw0bie;
    logic          rw0re;
    logic [AW-1:0] r1addr;
    logic          r1re;

    logic [NI-1:0] v0;
    logic [NI-1:0] v1;
    logic [DW-1:0] d0 [NI];
    logic [DW-1:0] d1 [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        alb_mss_fpga_sram_2p_mem_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) bus ();

        assign bus.rw0addr = rw0addr;
        assign bus.rw0di   = rw0di;
        assign bus.rw0we   = rw0we;
        assign bus.rw0bie  = rw0bie;
        assign bus.rw0re   = rw0re;
        assign bus.r1addr  = r1addr;
        assign bus.r1re    = r1re;

        alb_mss_fpga_sram_2p_mem #(
            .DATA_W  (DW),
            .BYTE_W  (BW),
            .ADDR_W  (AW),
            .RD_LAT  (int'(LAT_BITS[3*g +: 3])),
            .RW_MODE (int'(MODE_BITS[g]))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign v0[g] = bus.rw0dv;
        assign d0[g] = bus.rw0do;
        assign v1[g] = bus.r1dv;
        assign d1[g] = bus.r1do;
    end

    // Reference model: memory contents plus a per-edge log of issued reads.
    logic [DW-1:0] mem_m [1 << AW];
    bit            h_rst [MAXE];
    bit            h_v0  [MAXE];
    bit            h_v1  [MAXE];
    logic [DW-1:0] h0_rbw [MAXE];
    logic [DW-1:0] h0_wt  [MAXE];
    logic [DW-1:0] h1_rbw [MAXE];
    logic [DW-1:0] h1_wt  [MAXE];
    bit            ev0 [NI];
    bit            ev1 [NI];
    logic [DW-1:0] ed0 [NI];
    logic [DW-1:0] ed1 [NI];
    int            e = 0;
    int            errors = 0;
    int            checks = 0;

    function automatic int lat_of(input int k);
        logic [3*NI-1:0] lb;
        lb = LAT_BITS;
        return int'(lb[3*k +: 3]);
    endfunction

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [NB-1:0] bie);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (bie[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
        end
        return r;
    endfunction

    // One clock: log this edge's requests into the model, advance, derive expectations.
    task automatic tick();
        logic [DW-1:0] old0, old1, merged;
        logic          wr;
        old0   = mem_m[rw0addr];
        old1   = mem_m[r1addr];
        wr     = !rst && rw0we && (rw0bie != '0);
        merged = merge_m(old0, rw0di, rw0bie);
        h_rst[e]  = rst;
        h_v0[e]   = !rst && rw0re;
        h_v1[e]   = !rst && r1re;
        h0_rbw[e] = old0;
        h0_wt[e]  = wr ? merged : old0;
        h1_rbw[e] = old1;
        h1_wt[e]  = (wr && r1addr == rw0addr) ? merged : old1;
        if (wr) mem_m[rw0addr] = merged;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            int s;
            bit ok0, ok1, wt;
            wt  = MODE_BITS[k];
            s   = e - lat_of(k) + 1;
            ok0 = (s >= 0) && h_v0[s];
            ok1 = (s >= 0) && h_v1[s];
            for (int j = s + 1; j <= e; j++) begin
                if (j >= 0 && h_rst[j]) begin
                    ok0 = 1'b0;
                    ok1 = 1'b0;
                end
            end
            if (h_rst[e]) begin
                ed0[k] = '0;
                ed1[k] = '0;
            end
            if (ok0) ed0[k] = wt ? h0_wt[s] : h0_rbw[s];
            if (ok1) ed1[k] = wt ? h1_wt[s] : h1_rbw[s];
            ev0[k] = ok0;
            ev1[k] = ok1;
        end
        e++;
    endtask

    task automatic idle();
        rw0we  = 1'b0;
        rw0re  = 1'b0;
        r1re   = 1'b0;
        rw0bie = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rw0addr = '0; r1addr = '0; rw0di = '0;
        idle();
        repeat (3) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (v0[k] !== 1'b0 || v1[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_dv inst%0d: rw0dv=%b r1dv=%b, want 0 0", k, v0[k], v1[k]);
                end
                checks++;
                if (d0[k] !== '0 || d1[k] !== '0) begin
                    errors++;
                    $display("FAIL reset_do inst%0d: rw0do=%h r1do=%h, want 0 0", k, d0[k], d1[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic preload();
        for (int a = 0; a < (1 << AW); a++) begin
            rw0we   = 1'b1;
            rw0bie  = '1;
            rw0addr = AW'(a);
            if (a < 4)       rw0di = DW'(10 + a);
            else if (a == 7) rw0di = DW'(64'h1234);
            else             rw0di = {$urandom, $urandom};
            tick();
        end
        idle();
    endtask

    task automatic test_pipeline();
        for (int t = 1; t <= 8; t++) begin
            idle();
            if (t <= 4) begin
                r1re   = 1'b1;
                r1addr = AW'(t - 1);
            end
            tick();
            checks++;
            if (v1[4] !== ((t >= 3) && (t <= 6))) begin
                errors++;
                $display("FAIL pipe_r1dv cycle%0d: got %b want %b", t, v1[4], (t >= 3) && (t <= 6));
            end
            if (t >= 3) begin
                checks++;
                if (d1[4] !== DW'(10 + ((t <= 6) ? t - 3 : 3))) begin
                    errors++;
                    $display("FAIL pipe_r1do cycle%0d: got %0d want %0d", t, d1[4],
                             10 + ((t <= 6) ? t - 3 : 3));
                end
            end
        end
        idle();
    endtask

    task automatic test_rbw_collision();
        logic [DW-1:0] aa, ff55;
        aa   = {NB{8'hAA}};
        ff55 = {NB{8'h55}};
        idle();
        rw0we = 1'b1; rw0bie = '1; rw0addr = AW'(5); rw0di = aa;
        tick();
        rw0re = 1'b1; rw0di = ff55;
        tick();
        checks++;
        if (v0[0] !== 1'b1 || d0[0] !== aa) begin
            errors++;
            $display("FAIL rbw_same_addr: dv=%b do=%h want 1 %h", v0[0], d0[0], aa);
        end
        checks++;
        if (v0[1] !== 1'b1 || d0[1] !== ff55) begin
            errors++;
            $display("FAIL wt_same_addr: dv=%b do=%h want 1 %h", v0[1], d0[1], ff55);
        end
        idle();
        tick();
        checks++;
        if (v0[0] !== 1'b0 || d0[0] !== aa) begin
            errors++;
            $display("FAIL rbw_hold: dv=%b do=%h want 0 %h", v0[0], d0[0], aa);
        end
        rw0re = 1'b1;
        tick();
        checks++;
        if (v0[0] !== 1'b1 || d0[0] !== ff55) begin
            errors++;
            $display("FAIL rbw_later_read: dv=%b do=%h want 1 %h", v0[0], d0[0], ff55);
        end
        idle();
    endtask

    task automatic test_wt_lane();
        idle();
        rw0we = 1'b1; rw0bie = '1; rw0addr = AW'(3); rw0di = '0;
        tick();
        rw0di  = '1;
        rw0bie = NB'(1);
        r1re   = 1'b1;
        r1addr = AW'(3);
        tick();
        checks++;
        if (v1[1] !== 1'b1 || d1[1] !== DW'(64'hFF)) begin
            errors++;
            $display("FAIL wt_cross_port: dv=%b do=%h want 1 %h", v1[1], d1[1], DW'(64'hFF));
        end
        checks++;
        if (v1[0] !== 1'b1 || d1[0] !== '0) begin
            errors++;
            $display("FAIL rbw_cross_port: dv=%b do=%h want 1 0", v1[0], d1[0]);
        end
        idle();
        r1re = 1'b1;
        tick();
        checks++;
        if (d1[0] !== DW'(64'hFF)) begin
            errors++;
            $display("FAIL lane_written: do=%h want %h", d1[0], DW'(64'hFF));
        end
        idle();
    endtask

    task automatic test_bie_zero();
        idle();
        rw0we = 1'b1; rw0bie = '0; rw0addr = AW'(7); rw0di = '1;
        tick();
        idle();
        rw0re = 1'b1;
        tick();
        checks++;
        if (v0[0] !== 1'b1 || d0[0] !== DW'(64'h1234)) begin
            errors++;
            $display("FAIL bie_zero_lat1: dv=%b do=%h want 1 1234", v0[0], d0[0]);
        end
        idle();
        repeat (3) tick();
        checks++;
        if (v0[3] !== 1'b1 || d0[3] !== DW'(64'h1234)) begin
            errors++;
            $display("FAIL bie_zero_lat4: dv=%b do=%h want 1 1234", v0[3], d0[3]);
        end
    endtask

    task automatic test_reset_midflight();
        idle();
        rw0re = 1'b1; rw0addr = AW'(7);
        tick();
        idle();
        rst = 1'b1; rw0we = 1'b1; rw0bie = '1; rw0di = {NB{8'hDE}};
        tick();
        checks++;
        if (v0[5] !== 1'b0 || d0[5] !== '0) begin
            errors++;
            $display("FAIL midflight_edge1: dv=%b do=%h want 0 0", v0[5], d0[5]);
        end
        idle();
        tick();
        checks++;
        if (v0[5] !== 1'b0 || d0[5] !== '0) begin
            errors++;
            $display("FAIL midflight_edge2: dv=%b do=%h want 0 0", v0[5], d0[5]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (v0[5] !== 1'b0 || d0[5] !== '0) begin
            errors++;
            $display("FAIL midflight_release: dv=%b do=%h want 0 0", v0[5], d0[5]);
        end
        rw0re = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (v0[5] !== 1'b1 || d0[5] !== DW'(64'h1234)) begin
            errors++;
            $display("FAIL reset_write_blocked: dv=%b do=%h want 1 1234", v0[5], d0[5]);
        end
    endtask

    task automatic test_soak();
        for (int c = 0; c < 10000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            rw0addr = AW'($urandom_range(0, (1 << AW) - 1));
            r1addr  = ($urandom_range(0, 2) == 0) ? rw0addr : AW'($urandom_range(0, (1 << AW) - 1));
            rw0di   = {$urandom, $urandom};
            rw0bie  = NB'($urandom);
            rw0we   = $urandom_range(0, 1) == 1;
            rw0re   = $urandom_range(0, 1) == 1;
            r1re    = $urandom_range(0, 1) == 1;
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (v0[k] !== ev0[k] || d0[k] !== ed0[k]) begin
                    errors++;
                    $display("FAIL soak_rw0 inst%0d edge%0d: dv=%b do=%h want %b %h",
                             k, e, v0[k], d0[k], ev0[k], ed0[k]);
                end
                checks++;
                if (v1[k] !== ev1[k] || d1[k] !== ed1[k]) begin
                    errors++;
                    $display("FAIL soak_r1 inst%0d edge%0d: dv=%b do=%h want %b %h",
                             k, e, v1[k], d1[k], ev1[k], ed1[k]);
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            ed0[k] = '0;
            ed1[k] = '0;
        end
        test_reset();
        preload();
        test_pipeline();
        test_rbw_collision();
        test_wt_lane();
        test_bie_zero();
        test_reset_midflight();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alb_mss_fpga_sram_2p_mem.md
# alb_mss_fpga_sram_2p_mem

Parametrised two-port synchronous SRAM model for the MSS FPGA/emulation memory subsystem, succeeding the single-port 128-bit byte-masked RW memory. It provides one read/write port (rw0) and one independent read-only port (r1) on a single clock. It adds configurable width, depth, byte size, read latency and read/write collision mode, plus read-valid strobes. It backs fabric-facing SRAM regions where a DMA or debug reader runs alongside the core port.

## Interface
- `DATA_W`, 128: word width in bits; must be a multiple of `BYTE_W`.
- `BYTE_W`, 8: bits per byte lane; `NB = DATA_W/BYTE_W`.
- `ADDR_W`, 28: address width; depth = 2^`ADDR_W` words.
- `RD_LAT`, 1: read latency in cycles, legal range 1..4.
- `RW_MODE`, 0: collision mode. 0 = READ_BEFORE_WRITE, 1 = WRITE_THROUGH.
- `clk`  in  1  single clock, posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rw0addr`  in  ADDR_W  rw0 word address.
- `rw0di`  in  DATA_W  rw0 write data.
- `rw0we`  in  1  rw0 write enable, high.
- `rw0bie`  in  NB  rw0 byte-lane enable, one bit per lane, high.
- `rw0re`  in  1  rw0 read enable, high.
- `rw0do`  out  DATA_W  rw0 read data.
- `rw0dv`  out  1  rw0 read data valid, one pulse per accepted read.
- `r1addr`  in  ADDR_W  r1 word address.
- `r1re`  in  1  r1 read enable.
- `r1do`  out  DATA_W  r1 read data.
- `r1dv`  out  1  r1 read data valid.

## Operation
- Write, rw0: when `rw0we`=1 and `rst`=0, each lane i with `rw0bie[i]`=1 takes `rw0di[i*BYTE_W +: BYTE_W]`. Lanes with `bie`=0 are unchanged. If all `bie` bits are 0, no write occurs.
- Read: when `re`=1 and `rst`=0, the port samples the array word at `addr` at the clock edge. That word propagates through an `RD_LAT`-stage pipeline to `do`, with `dv` high in the same cycle.
- rw0 same-address read+write in one cycle:
  - READ_BEFORE_WRITE returns the pre-write word.
  - WRITE_THROUGH returns the merged post-write word.
- Cross-port collision (r1 reads the address rw0 writes in the same cycle) obeys `RW_MODE` identically. The WRITE_THROUGH result is the lane-merged word.
- Back-to-back reads are fully pipelined: one read per port per cycle, responses in issue order.
- `do` holds the last delivered value while `dv`=0. It never shows X from idle pipeline stages.
- Memory contents are not cleared by reset. Simulation init is all-zero under the `ZFMCHECK_SIM` define.
- Reset:
  - While `rst`=1, reads and writes are ignored.
  - All pipeline valid bits clear; `rw0do`/`r1do` = 0 and `rw0dv`/`r1dv` = 0 from the first edge with `rst`=1.
  - Reads in flight when reset asserts are dropped: no `dv` is produced for them.
- Illegal parameters (`DATA_W % BYTE_W` ≠ 0, or `RD_LAT` outside 1..4) are rejected at elaboration with `$error`.

## Timing
- Read issued at edge N: `do`/`dv` are valid after edge N+`RD_LAT-1`, i.e. sampled at edge N+`RD_LAT`. With `RD_LAT`=1 this matches the legacy single-cycle behaviour.
- A write at edge N is visible to any read issued at edge N+1 or later, in either mode.
- Reset release: the first read issues at the first edge with `rst`=0; its `dv` follows `RD_LAT` later.
- No handshake backpressure. Consumers must accept `dv` pulses when they occur.

## Structure
- Package `alb_mss_sram_pkg` holds:
  - enum `rw_mode_e` {RBW=0, WT=1};
  - constant `MAX_RD_LAT`=4;
  - function `lane_merge(old, new, bie)`, used by both the write path and the WRITE_THROUGH bypass.
- Sub-module `alb_mss_sram_rd_pipe`, parametrised by `DATA_W` and `RD_LAT`:
  - contains the valid/data shift register with hold-on-idle output and synchronous flush;
  - instantiated once per read port.
- The top level contains the sparse array, write merge and collision bypass muxes.

## Test plan
- RBW, `RD_LAT`=1: write 0x…AA at addr 5 with all lanes enabled, then read and write 0x…55 at addr 5 in the same cycle. Required: `rw0do`=0x…AA with `rw0dv` the next cycle; a later read returns 0x…55.
- WT, `BYTE_W`=8: addr 3 holds 0x00…00; write `rw0di`=all 0xFF with `bie`=0x0001 while r1 reads addr 3 in the same cycle. Required: `r1do`=0x00…00FF. The same scenario in RBW gives 0x00…00.
- `RD_LAT`=3: four back-to-back r1 reads of addrs 0..3, holding values 10..13. Required: `r1dv` high for exactly cycles 3..6, data 10,11,12,13 in order, and `r1do` holds 13 afterwards.
- `bie`=0 with `rw0we`=1 to addr 7, which holds 0x1234. Required: a read returns 0x1234.
- Reset mid-flight (`RD_LAT`=2): issue a read, assert `rst` on the next edge. Required: no `dv`, `do`=0; a write attempted during reset does not land.
- Random soak: both ports with random address/`bie`/`re`/`we` over 10k cycles, checked against a reference model in both modes and at `RD_LAT` 1 and 4.
